// File: rtl/mux3_pkg.sv
// ============================================================================
//  mux3_pkg : shared selector encodings and requester count for the 3:1 arbiter
//  Rev 1.0
// ============================================================================
`default_nettype none

package mux3_pkg;
    localparam logic [1:0] SEL_C0  = 2'b00;
    localparam logic [1:0] SEL_C1  = 2'b01;
    localparam logic [1:0] SEL_C2  = 2'b10;
    localparam int         NUM_REQ = 3;
endpackage

`default_nettype wire

// File: rtl/rr_pick3.sv
// ============================================================================
//  rr_pick3 : combinational round-robin pick among three requesters
//  Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick3
    import mux3_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         win,
    output logic               any
);

    // The most recent winner always drops to lowest priority.
    always_comb begin
        win = SEL_C0;
        case (last)
            SEL_C0: begin
                if (req[1])      win = SEL_C1;
                else if (req[2]) win = SEL_C2;
                else             win = SEL_C0;
            end
            SEL_C1: begin
                if (req[2])      win = SEL_C2;
                else if (req[0]) win = SEL_C0;
                else             win = SEL_C1;
            end
            default: begin
                if (req[0])      win = SEL_C0;
                else if (req[1]) win = SEL_C1;
                else             win = SEL_C2;
            end
        endcase
    end

    assign any   = |req;
    assign grant = any ? (3'b001 << win) : 3'b000;

endmodule

`default_nettype wire

// File: rtl/mux3_rr_arbiter.sv
// ============================================================================
//  mux3_rr_arbiter : round-robin 3:1 mux with registered, tagged output stage
//  Rev 1.0
// ============================================================================
`default_nettype none

module mux3_rr_arbiter
    import mux3_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [DATA_W-1:0]   choice_0,
    input  logic [DATA_W-1:0]   choice_1,
    input  logic [DATA_W-1:0]   choice_2,
    output logic [NUM_REQ-1:0]  grant,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_sel,
    output logic                out_valid,
    input  logic                out_ready
);

    logic [DATA_W-1:0]  r_out_data;
    logic [1:0]         r_out_sel;
    logic               r_out_valid;
    logic [1:0]         r_last;

    logic [NUM_REQ-1:0] w_grant_raw;
    logic [1:0]         w_win;
    logic               w_any;
    logic               w_load;
    logic [DATA_W-1:0]  w_win_data;

    rr_pick3 u_pick (
        .req   (req),
        .last  (r_last),
        .grant (w_grant_raw),
        .win   (w_win),
        .any   (w_any)
    );

    assign w_load = !r_out_valid || out_ready;

    // rst_n gates grant directly so it drops during reset without waiting for an edge.
    assign grant = (rst_n && w_load) ? w_grant_raw : 3'b000;

    always_comb begin
        case (w_win)
            SEL_C0:  w_win_data = choice_0;
            SEL_C1:  w_win_data = choice_1;
            default: w_win_data = choice_2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_sel   <= SEL_C0;
            r_out_valid <= 1'b0;
            r_last      <= SEL_C2;
        end else if (w_load) begin
            if (w_any) begin
                r_out_data  <= w_win_data;
                r_out_sel   <= w_win;
                r_out_valid <= 1'b1;
                r_last      <= w_win;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux3_rr_arbiter.sv
// ============================================================================
//  tb_mux3_rr_arbiter : directed self-checking bench for mux3_rr_arbiter
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux3_rr_arbiter;

    localparam int DATA_W = 24;

    logic              clk;
    logic              rst_n;
    logic [2:0]        req;
    logic [DATA_W-1:0] choice_0;
    logic [DATA_W-1:0] choice_1;
    logic [DATA_W-1:0] choice_2;
    logic [2:0]        grant;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_sel;
    logic              out_valid;
    logic              out_ready;

    int checks   = 0;
    int failures = 0;

    mux3_rr_arbiter #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .choice_0  (choice_0),
        .choice_1  (choice_1),
        .choice_2  (choice_2),
        .grant     (grant),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Check combinational grant shortly after inputs change, then registered outputs after the edge.
    task automatic cycle(input string tag, input logic [2:0] exp_grant, input logic exp_valid,
                         input logic [1:0] exp_sel, input logic [DATA_W-1:0] exp_data);
        #1;
        chk({tag, "_grant"}, {29'd0, grant}, {29'd0, exp_grant});
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
        chk({tag, "_sel"},   {30'd0, out_sel},   {30'd0, exp_sel});
        chk({tag, "_data"},  {8'd0, out_data},   {8'd0, exp_data});
        @(negedge clk);
    endtask

    logic [2:0]        rr_grant [4];
    logic [1:0]        rr_sel   [4];
    logic [DATA_W-1:0] rr_data  [4];

    initial begin
        rr_grant = '{3'b001, 3'b010, 3'b100, 3'b001};
        rr_sel   = '{2'b00, 2'b01, 2'b10, 2'b00};
        rr_data  = '{24'h111111, 24'h222222, 24'h333333, 24'h111111};

        rst_n     = 1'b0;
        req       = 3'b111;
        out_ready = 1'b0;
        choice_0  = 24'h111111;
        choice_1  = 24'h222222;
        choice_2  = 24'h333333;

        #3;
        chk("rst_grant", {29'd0, grant},     32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data",  {8'd0, out_data},   32'd0);
        chk("rst_sel",   {30'd0, out_sel},   32'd0);

        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            cycle("rr", rr_grant[i], 1'b1, rr_sel[i], rr_data[i]);

        // Stall: output full, downstream not ready.
        out_ready = 1'b0;
        repeat (3) cycle("stall", 3'b000, 1'b1, 2'b00, 24'h111111);
        out_ready = 1'b1;
        cycle("resume", 3'b010, 1'b1, 2'b01, 24'h222222);

        req      = 3'b010;
        choice_1 = 24'hABCDEF;
        cycle("single", 3'b010, 1'b1, 2'b01, 24'hABCDEF);

        req = 3'b100;
        cycle("to_last2", 3'b100, 1'b1, 2'b10, 24'h333333);
        req = 3'b101;
        cycle("r101_a", 3'b001, 1'b1, 2'b00, 24'h111111);
        cycle("r101_b", 3'b100, 1'b1, 2'b10, 24'h333333);
        req = 3'b000;
        cycle("drain", 3'b000, 1'b0, 2'b10, 24'h333333);

        choice_0  = 24'h123456;
        req       = 3'b001;
        out_ready = 1'b0;
        cycle("fill", 3'b001, 1'b1, 2'b00, 24'h123456);

        req = 3'b111;
        #1;
        chk("full_grant", {29'd0, grant}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_grant", {29'd0, grant},     32'd0);
        chk("midrst_data",  {8'd0, out_data},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("postrst", 3'b001, 1'b1, 2'b00, 24'h123456);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
